// File: rtl/verilog_alu.sv
// Registered RV32I integer ALU: decodes OP / OP-IMM instruction words,
// executes the arithmetic/logic operation on the supplied operand values
// and registers the 32-bit result together with an illegal-instruction flag.
// No handshake: every cycle is a new operation. The result and the flag
// appear one edge after the inputs that produced them.
module verilog_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [31:0] I,
    output logic [31:0] o,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Selected ALU operation after decode; ALU_NONE marks an unsupported word.
    typedef enum logic [3:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm;
    logic        w_is_r;
    logic        w_is_i;
    logic [31:0] w_b;
    logic [4:0]  w_shamt;
    alu_op_e     w_op;
    logic [31:0] w_result;
    logic        w_illegal;

    logic [31:0] r_o;
    logic        r_illegal;

    assign w_opcode = I[6:0];
    assign w_funct3 = I[14:12];
    assign w_funct7 = I[31:25];
    assign w_imm    = {{20{I[31]}}, I[31:20]};
    assign w_is_r   = (w_opcode == OPC_OP);
    assign w_is_i   = (w_opcode == OPC_OP_IMM);

    // Operand B and shift amount: rs2 for register ops, immediate/shamt for
    // immediate ops (shamt is I[24:20], i.e. the low five immediate bits).
    assign w_b     = w_is_r ? rs2 : w_imm;
    assign w_shamt = w_b[4:0];

    // Decode opcode/funct3/funct7 into one operation or ALU_NONE.
    always_comb begin
        w_op = ALU_NONE;
        if (w_is_r) begin
            if (w_funct7 == F7_BASE) begin
                case (w_funct3)
                    3'b000:  w_op = ALU_ADD;
                    3'b001:  w_op = ALU_SLL;
                    3'b010:  w_op = ALU_SLT;
                    3'b011:  w_op = ALU_SLTU;
                    3'b100:  w_op = ALU_XOR;
                    3'b101:  w_op = ALU_SRL;
                    3'b110:  w_op = ALU_OR;
                    default: w_op = ALU_AND;
                endcase
            end else if (w_funct7 == F7_ALT) begin
                if (w_funct3 == 3'b000) begin
                    w_op = ALU_SUB;
                end else if (w_funct3 == 3'b101) begin
                    w_op = ALU_SRA;
                end
            end
        end else if (w_is_i) begin
            // funct7 field is immediate payload except for the shift forms.
            case (w_funct3)
                3'b000:  w_op = ALU_ADD;
                3'b001:  w_op = (w_funct7 == F7_BASE) ? ALU_SLL : ALU_NONE;
                3'b010:  w_op = ALU_SLT;
                3'b011:  w_op = ALU_SLTU;
                3'b100:  w_op = ALU_XOR;
                3'b101: begin
                    if (w_funct7 == F7_BASE) begin
                        w_op = ALU_SRL;
                    end else if (w_funct7 == F7_ALT) begin
                        w_op = ALU_SRA;
                    end
                end
                3'b110:  w_op = ALU_OR;
                default: w_op = ALU_AND;
            endcase
        end
    end

    // Execute the decoded operation; unsupported words produce zero.
    always_comb begin
        w_result  = 32'd0;
        w_illegal = 1'b0;
        case (w_op)
            ALU_ADD:  w_result = rs1 + w_b;
            ALU_SUB:  w_result = rs1 - w_b;
            ALU_SLL:  w_result = rs1 << w_shamt;
            ALU_SLT:  w_result = {31'd0, ($signed(rs1) < $signed(w_b))};
            ALU_SLTU: w_result = {31'd0, (rs1 < w_b)};
            ALU_XOR:  w_result = rs1 ^ w_b;
            ALU_SRL:  w_result = rs1 >> w_shamt;
            ALU_SRA:  w_result = $unsigned($signed(rs1) >>> w_shamt);
            ALU_OR:   w_result = rs1 | w_b;
            ALU_AND:  w_result = rs1 & w_b;
            default: begin
                w_result  = 32'd0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Output register; reset clears both outputs without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o       <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_o       <= w_result;
            r_illegal <= w_illegal;
        end
    end

    assign o       = r_o;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_verilog_alu.sv
// Bench for verilog_alu: directed checks from the worked examples, reset
// behaviour, then randomized instruction words against a reference model.
module tb_verilog_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] I;
    logic [31:0] o;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    verilog_alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs1     (rs1),
        .rs2     (rs2),
        .I       (I),
        .o       (o),
        .illegal (illegal)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural meaning of each mnemonic.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] r2,
                                      input logic [31:0] ins,
                                      output logic [31:0] eo, output logic eill);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] b;
        int          sh;
        logic        is_r;
        opc  = ins[6:0];
        f3   = ins[14:12];
        f7   = ins[31:25];
        is_r = (opc == 7'h33);
        b    = is_r ? r2 : {{20{ins[31]}}, ins[31:20]};
        sh   = int'(b % 32);
        eo   = 32'd0;
        eill = 1'b0;
        if (opc != 7'h33 && opc != 7'h13) begin
            eill = 1'b1;
        end else if (is_r && !(f7 == 7'h00 ||
                               (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) begin
            eill = 1'b1;
        end else if (!is_r && f3 == 3'd1 && f7 != 7'h00) begin
            eill = 1'b1;
        end else if (!is_r && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) begin
            eill = 1'b1;
        end else begin
            case (f3)
                3'd0: eo = (is_r && f7 == 7'h20) ? a - b : a + b;
                3'd1: eo = a * (32'd1 << sh);
                3'd2: eo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: eo = (a < b) ? 32'd1 : 32'd0;
                3'd4: eo = a ^ b;
                3'd5: begin
                    eo = a / (32'd1 << sh);
                    // arithmetic: fill vacated upper bits with the sign bit
                    if (f7 == 7'h20 && a[31] && sh != 0)
                        eo = eo | ~(32'hFFFF_FFFF >> sh);
                end
                3'd6: eo = a | b;
                default: eo = a & b;
            endcase
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: apply one operation at the falling edge, sample after the rising edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ins);
        @(negedge clk);
        rs1 = a;
        rs2 = b;
        I   = ins;
        @(posedge clk);
        #1;
    endtask

    // Apply and check one operation against explicit expected values.
    task automatic step_exp(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ins, input logic [31:0] eo, input logic eill);
        step(a, b, ins);
        check({tag, "_o"}, o, eo);
        check({tag, "_ill"}, {31'd0, illegal}, {31'd0, eill});
    endtask

    // Apply and check one operation against the reference model.
    task automatic step_ref(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ins);
        logic [31:0] eo;
        logic        eill;
        ref_model(a, b, ins, eo, eill);
        step(a, b, ins);
        check({tag, "_o"}, o, eo);
        check({tag, "_ill"}, {31'd0, illegal}, {31'd0, eill});
    endtask

    initial begin
        logic [31:0] ra, rb, ins;
        logic [6:0]  opcs [4];
        logic [6:0]  f7s  [3];
        opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h37; opcs[3] = 7'h33;
        f7s[0]  = 7'h00; f7s[1]  = 7'h20; f7s[2]  = 7'h01;

        rst_n = 1'b0;
        rs1   = 32'd0;
        rs2   = 32'd0;
        I     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_o", o, 32'd0);
        check("reset_ill", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Worked examples
        step_exp("add",  32'd10000, 32'd23456, 32'h003100B3, 32'd33456, 1'b0);
        step_exp("sub",  32'd10000, 32'd23456, 32'h403100B3, 32'hFFFFCB70, 1'b0);
        step_exp("sll0", 32'd10000, 32'd23456, 32'h003110B3, 32'd10000, 1'b0);
        step_exp("or",   32'd10000, 32'd23456, 32'h003160B3, 32'h00007FB0, 1'b0);
        step_exp("and",  32'd10000, 32'd23456, 32'h003170B3, 32'h00000300, 1'b0);
        step_exp("sra",  32'h80000000, 32'd4, 32'h403150B3, 32'hF8000000, 1'b0);
        step_exp("srl",  32'h80000000, 32'd4, 32'h003150B3, 32'h08000000, 1'b0);
        step_exp("slt",  32'h80000000, 32'd4, 32'h003120B3, 32'd1, 1'b0);
        step_exp("sltu", 32'h80000000, 32'd4, 32'h003130B3, 32'd0, 1'b0);
        step_exp("addi", 32'd5, 32'd0, 32'hFFF10093, 32'd4, 1'b0);
        step_exp("xori", 32'd5, 32'd0, 32'h0FF14093, 32'h000000FA, 1'b0);
        step_exp("ill_opc", 32'd10000, 32'd23456, 32'h00310037, 32'd0, 1'b1);
        step_exp("ill_f7",  32'd10000, 32'd23456, 32'h403160B3, 32'd0, 1'b1);
        // Boundary: shift amounts use only five bits, shift forms need exact funct7
        step_exp("sll_wrap", 32'd1, 32'h00000021, 32'h003110B3, 32'd2, 1'b0);
        step_exp("srai31", 32'h80000000, 32'd0, 32'h41F15093, 32'hFFFFFFFF, 1'b0);
        step_exp("slli_bad", 32'd1, 32'd0, 32'h02111093, 32'd0, 1'b1);
        step_exp("srli_bad", 32'd1, 32'd0, 32'h60115093, 32'd0, 1'b1);
        step_exp("sltiu_m1", 32'd7, 32'd0, 32'hFFF13093, 32'd1, 1'b0);

        // Asynchronous reset mid-cycle, held across two edges, then release
        step_exp("pre_rst", 32'd10000, 32'd23456, 32'h003100B3, 32'd33456, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_o", o, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("rst_hold_o", o, 32'd0);
            check("rst_hold_ill", {31'd0, illegal}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_o", o, 32'd33456);
        check("rst_release_ill", {31'd0, illegal}, 32'd0);

        // Randomized instruction words against the reference model
        for (int n = 0; n < 400; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
            ins = $urandom;
            ins[6:0] = opcs[$urandom_range(0, 3)];
            if ($urandom_range(0, 1) == 1) ins[31:25] = f7s[$urandom_range(0, 2)];
            if ($urandom_range(0, 15) == 0) ins[6:0] = 7'($urandom);
            step_ref("rand", ra, rb, ins);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
